// File: rtl/divider_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit: FSM encoding,
// step count and the sign-magnitude helper used at operand capture.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int unsigned DIV_STEPS = 32;
    localparam logic [5:0]  LAST_STEP = 6'(DIV_STEPS - 1);

    // Magnitude of a two's-complement operand; 32'h80000000 maps to itself,
    // which is exactly the unsigned magnitude the restoring loop needs.
    function automatic logic [31:0] abs_if(input logic en, input logic [31:0] v);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Execute-stage divide handshake: operands and control in, stall/done/results out.
interface divider_if;

    logic        startE;
    logic        signedE;
    logic [31:0] srcAE;
    logic [31:0] srcBE;
    logic        cancelE;
    logic        stallDivE;
    logic        doneE;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    modport master (
        output startE, signedE, srcAE, srcBE, cancelE,
        input  stallDivE, doneE, hiOut, loOut
    );

    modport slave (
        input  startE, signedE, srcAE, srcBE, cancelE,
        output stallDivE, doneE, hiOut, loOut
    );

endinterface

// File: rtl/divider_div_step.sv
// One combinational restoring-division step on the {remainder, quotient} register.
module div_step (
    input  logic [63:0] i_rem,
    input  logic [31:0] i_divisor,
    output logic [63:0] o_rem
);

    logic [32:0] w_hi_shift;
    logic [31:0] w_sub;
    logic        w_fits;

    // The shifted partial remainder can reach 33 bits, so compare at that width.
    assign w_hi_shift = i_rem[63:31];
    assign w_sub      = i_rem[62:31] - i_divisor;
    assign w_fits     = (w_hi_shift >= {1'b0, i_divisor});

    assign o_rem = w_fits ? {w_sub, i_rem[30:0], 1'b1}
                          : {i_rem[62:0], 1'b0};

endmodule

// File: rtl/divider.sv
// Multi-cycle DIV/DIVU unit: 32 restoring steps, stalls the front of the
// pipeline until the result is ready, and pulses doneE for the HI/LO write.
module divider
    import divider_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    divider_if.slave bus
);

    div_state_t  r_state;
    div_state_t  w_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_rem;
    logic [63:0] w_rem_step;
    logic [31:0] r_divisor;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_qneg;
    logic        r_rneg;
    logic        w_start;
    logic        w_div0;
    logic        w_last;

    assign w_start = bus.startE && !bus.cancelE && (r_state == IDLE);
    assign w_div0  = (bus.srcBE == '0);
    assign w_last  = (r_state == BUSY) && (r_cnt == LAST_STEP);

    div_step u_step (
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_step)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.cancelE) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.startE) w_next = w_div0 ? DONE : BUSY;
                BUSY:    if (r_cnt == LAST_STEP) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stallDivE = bus.startE && !bus.cancelE && (r_state != DONE);
        bus.doneE     = (r_state == DONE);
    end

    // Results are registered on entry to DONE so they are valid during the doneE pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_start) begin
            if (w_div0) begin
                r_lo <= '1;
                r_hi <= bus.srcAE;
            end else begin
                r_rem     <= {32'd0, abs_if(bus.signedE, bus.srcAE)};
                r_divisor <= abs_if(bus.signedE, bus.srcBE);
                r_qneg    <= bus.signedE && (bus.srcAE[31] ^ bus.srcBE[31]);
                r_rneg    <= bus.signedE && bus.srcAE[31];
                r_cnt     <= '0;
            end
        end else if ((r_state == BUSY) && !bus.cancelE) begin
            r_rem <= w_rem_step;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
                r_lo <= r_qneg ? (~w_rem_step[31:0] + 32'd1)  : w_rem_step[31:0];
                r_hi <= r_rneg ? (~w_rem_step[63:32] + 32'd1) : w_rem_step[63:32];
            end
        end
    end

    assign bus.hiOut = r_hi;
    assign bus.loOut = r_lo;

endmodule
